// File: rtl/mu0_pkg.sv
// Shared encodings for the MU0 control unit: opcodes, ALU functions, mux selects, states.
package mu0_pkg;

  localparam int unsigned ADRW = 12;
  localparam int unsigned OPW  = 4;
  localparam int unsigned AFW  = 4;
  localparam int unsigned BSW  = 2;

  localparam logic [OPW-1:0] OP_LDA = 4'h0;
  localparam logic [OPW-1:0] OP_STO = 4'h1;
  localparam logic [OPW-1:0] OP_ADD = 4'h2;
  localparam logic [OPW-1:0] OP_SUB = 4'h3;
  localparam logic [OPW-1:0] OP_JMP = 4'h4;
  localparam logic [OPW-1:0] OP_JGE = 4'h5;
  localparam logic [OPW-1:0] OP_JNE = 4'h6;
  localparam logic [OPW-1:0] OP_STP = 4'h7;
  localparam logic [OPW-1:0] OP_DEC = 4'h8;
  localparam logic [OPW-1:0] OP_MUL = 4'h9;
  localparam logic [OPW-1:0] OP_SHR = 4'hA;

  localparam logic [AFW-1:0] ALU_ZERO  = 4'd0;
  localparam logic [AFW-1:0] ALU_ADD   = 4'd1;
  localparam logic [AFW-1:0] ALU_SUB   = 4'd2;
  localparam logic [AFW-1:0] ALU_PASSB = 4'd3;
  localparam logic [AFW-1:0] ALU_INCB  = 4'd4;
  localparam logic [AFW-1:0] ALU_INCA  = 4'd5;
  localparam logic [AFW-1:0] ALU_DECA  = 4'd6;
  localparam logic [AFW-1:0] ALU_MUL   = 4'd7;
  localparam logic [AFW-1:0] ALU_SHR   = 4'd8;

  localparam logic [BSW-1:0] BSEL_MEM = 2'd0;
  localparam logic [BSW-1:0] BSEL_PC  = 2'd1;
  localparam logic [BSW-1:0] BSEL_IR  = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // EXEC-phase control word; enables here are before wait-state gating
  typedef struct packed {
    logic [AFW-1:0] alufs;
    logic           asel;
    logic [BSW-1:0] bsel;
    logic           acc_ce;
    logic           pc_ce;
    logic           acc_oe;
    logic           mem_rq;
    logic           rnw;
    logic           is_stp;
    logic           illegal;
  } exec_ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational opcode decode producing the EXEC-phase control word.
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  input  logic           acc_z,
  input  logic           acc_n,
  output exec_ctrl_t     ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_LDA: begin
        ctrl.mem_rq = 1'b1; ctrl.asel = 1'b1; ctrl.rnw = 1'b1;
        ctrl.bsel = BSEL_MEM; ctrl.alufs = ALU_PASSB; ctrl.acc_ce = 1'b1;
      end
      OP_STO: begin
        ctrl.mem_rq = 1'b1; ctrl.asel = 1'b1; ctrl.acc_oe = 1'b1;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        ctrl.mem_rq = 1'b1; ctrl.asel = 1'b1; ctrl.rnw = 1'b1;
        ctrl.bsel = BSEL_MEM; ctrl.acc_ce = 1'b1;
        ctrl.alufs = (opcode == OP_ADD) ? ALU_ADD :
                     (opcode == OP_SUB) ? ALU_SUB : ALU_MUL;
      end
      OP_JMP, OP_JGE, OP_JNE: begin
        ctrl.bsel  = BSEL_IR;
        ctrl.alufs = ALU_PASSB;
        ctrl.pc_ce = (opcode == OP_JMP) ? 1'b1 :
                     (opcode == OP_JGE) ? ~acc_n : ~acc_z;
      end
      OP_DEC: begin
        ctrl.alufs = ALU_DECA; ctrl.acc_ce = 1'b1;
      end
      OP_SHR: begin
        ctrl.alufs = ALU_SHR; ctrl.acc_ce = 1'b1;
      end
      OP_STP:  ctrl.is_stp  = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 sequencing control: fetch/execute FSM with memory wait states, halt and retire counter.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned IRW  = 16,
  parameter int unsigned CNTW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IRW-ADRW-1:0]     opcode,
  input  logic                    acc_z,
  input  logic                    acc_n,
  input  logic                    mem_ready,
  input  logic                    go,
  output logic [AFW-1:0]          ALUfs,
  output logic                    Asel,
  output logic [BSW-1:0]          Bsel,
  output logic                    ACCce,
  output logic                    PCce,
  output logic                    IRce,
  output logic                    ACCoe,
  output logic                    MEMrq,
  output logic                    RnW,
  output logic                    halted,
  output logic                    illegal_op,
  output logic [CNTW-1:0]         instr_count
);

  state_t     state_q, state_d;
  exec_ctrl_t dec;
  logic       retire;
  logic       done;

  mu0_decode u_decode (
    .opcode (OPW'(opcode)),
    .acc_z  (acc_z),
    .acc_n  (acc_n),
    .ctrl   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + CNTW'(1);
    end
  end

  // Next state and outputs; selects stay stable across waits, only enables gate on mem_ready
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    done       = 1'b0;
    ALUfs      = ALU_ZERO;
    Asel       = 1'b0;
    Bsel       = BSEL_MEM;
    ACCce      = 1'b0;
    PCce       = 1'b0;
    IRce       = 1'b0;
    ACCoe      = 1'b0;
    MEMrq      = 1'b0;
    RnW        = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        MEMrq = 1'b1;
        RnW   = 1'b1;
        Bsel  = BSEL_PC;
        ALUfs = ALU_INCB;
        if (mem_ready) begin
          IRce    = 1'b1;
          PCce    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        done       = dec.mem_rq ? mem_ready : 1'b1;
        ALUfs      = dec.alufs;
        Asel       = dec.asel;
        Bsel       = dec.bsel;
        MEMrq      = dec.mem_rq;
        RnW        = dec.rnw;
        ACCoe      = dec.acc_oe;
        ACCce      = dec.acc_ce & done;
        PCce       = dec.pc_ce & done;
        illegal_op = dec.illegal;
        if (done) begin
          retire  = 1'b1;
          state_d = dec.is_stp ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (go) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Outputs are forced low for as long as reset is held
    if (!rst_n) begin
      ALUfs      = ALU_ZERO;
      Asel       = 1'b0;
      Bsel       = BSEL_MEM;
      ACCce      = 1'b0;
      PCce       = 1'b0;
      IRce       = 1'b0;
      ACCoe      = 1'b0;
      MEMrq      = 1'b0;
      RnW        = 1'b0;
      halted     = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Sequencing control unit for the MU0 processor. It sits directly upstream of the ALU and generates ALUfs plus all datapath mux selects, register enables and memory strobes.
- It runs a fetch/execute state machine with memory wait states and a halt state.
- It decodes IR[15:12] against the extended MU0 instruction set, which adds DEC, MUL and SHR.

Parameters:
- IRW, 16, instruction/data word width.
- CNTW, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  IR[15:12], from the datapath IR register.
- acc_z  in  1  ACC == 0, from the datapath.
- acc_n  in  1  ACC[15], from the datapath.
- mem_ready  in  1  memory completes the current access this cycle.
- go  in  1  leave HALT and resume fetching.
- ALUfs  out  4  ALU function select (0 zero, 1 A+B, 2 A-B, 3 B, 4 B+1, 5 A+1, 6 A-1, 7 A*B, 8 A>>1).
- Asel  out  1  address mux: 0 = PC, 1 = IR[11:0].
- Bsel  out  2  ALU B mux: 0 = mem data, 1 = PC, 2 = IR[11:0] zero-extended.
- ACCce  out  1  ACC load enable.
- PCce  out  1  PC load enable.
- IRce  out  1  IR load enable.
- ACCoe  out  1  ACC drives memory write bus.
- MEMrq  out  1  memory request.
- RnW  out  1  1 = read, 0 = write.
- halted  out  1  FSM is in HALT.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNTW  retired-instruction counter.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State goes to FETCH and instr_count goes to 0.
  - All outputs are forced to 0 while rst_n is low, including ALUfs = 0, RnW = 0, halted = 0 and illegal_op = 0.
- States: FETCH, EXEC, HALT. Outputs are combinational from state, opcode, flags and mem_ready.
- FETCH:
  - Drive MEMrq = 1, RnW = 1, Asel = 0, Bsel = 1, ALUfs = 4.
  - IRce and PCce are asserted only in the cycle mem_ready = 1 (PC <= PC+1, IR <= mem). The FSM then moves to EXEC; otherwise it stays in FETCH.
- EXEC, memory-operand opcodes: MEMrq = 1, Asel = 1. Enables are asserted only when mem_ready = 1, and the FSM stays in EXEC until then.
  - 0 LDA: RnW = 1, Bsel = 0, ALUfs = 3, ACCce.
  - 1 STO: RnW = 0, ACCoe = 1, no register enable.
  - 2 ADD: RnW = 1, Bsel = 0, ALUfs = 1, ACCce.
  - 3 SUB: as ADD but ALUfs = 2.
  - 9 MUL: as ADD but ALUfs = 7.
- EXEC, single-cycle opcodes (no memory access, complete in one cycle):
  - 4 JMP: Bsel = 2, ALUfs = 3, PCce.
  - 5 JGE: as JMP, but PCce only if acc_n = 0.
  - 6 JNE: as JMP, but PCce only if acc_z = 0.
  - 8 DEC: ALUfs = 6, ACCce.
  - A SHR: ALUfs = 8, ACCce.
  - 7 STP: no enables; next state is HALT.
  - B–F: no enables; illegal_op = 1 for that cycle; treated as NOP.
- EXEC completion:
  - On completion, instr_count increments and the next state is FETCH (HALT for STP).
  - STP and illegal opcodes also count as retired.
  - The counter wraps from all-ones to 0.
- HALT:
  - halted = 1 and all enables/requests are 0.
  - go = 1 moves the FSM to FETCH next cycle; go is ignored in all other states.
- During every wait cycle (mem_ready = 0), MEMrq, Asel, Bsel, RnW and ALUfs are held stable and all clock enables are 0.
- A taken branch has no extra latency. Nominal CPI is 2; each wait cycle adds 1.
- Reset asserted mid-access immediately drops MEMrq and all enables. The FSM restarts in FETCH.

Decomposition:
- Shared package mu0_pkg holds:
  - opcode localparams: OP_LDA … OP_SHR.
  - ALUfs codes: ALU_ZERO, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_INCB, ALU_INCA, ALU_DECA, ALU_MUL, ALU_SHR.
  - Bsel and state encodings.
- One natural sub-module: mu0_decode, purely combinational, mapping (opcode, acc_z, acc_n) to the EXEC control word. mu0_control owns the FSM, wait-state gating and counter.

Test Plan:
- Reset release, mem_ready = 1 constant:
  - Cycle 1 is FETCH with ALUfs = 4, Bsel = 1, IRce = PCce = 1.
  - Opcode 2 then gives EXEC with ALUfs = 1, Asel = 1, ACCce = 1, and instr_count = 1 after that edge.
- FETCH with mem_ready low for 3 cycles:
  - MEMrq = 1 held and IRce = 0 for 3 cycles.
  - IRce = 1 in the 4th cycle, then EXEC.
- JGE with acc_n = 1: PCce = 0. JGE with acc_n = 0: PCce = 1, Bsel = 2, ALUfs = 3. JNE with acc_z = 1: PCce = 0.
- STO with mem_ready delayed 2 cycles: RnW = 0 and ACCoe = 1 held 3 cycles, no ACCce, then FETCH.
- Opcode 7: HALT, halted = 1, all enables 0 for 5 cycles with go = 0. go = 1 gives FETCH next cycle and halted = 0.
- Opcode D: illegal_op pulses for 1 cycle, no enables, instr_count increments, returns to FETCH.
- rst_n low mid-EXEC of MUL: all outputs 0 immediately, instr_count = 0; after release, state is FETCH.
